tdma_slot_sequencer: RTL
========================

# tdma_slot_sequencer

Parametrised multi-slot TDMA frame generator. It is the next generation of the single-slot TDMA slot generator and sits behind the same AXI4-Lite register shim in the IP library. It divides time into a frame of NUM_SLOTS slots, each with its own programmable length. It drives a one-hot slot-active bus and a frame-start strobe, can lock frame start to an external sync pulse, and raises a level interrupt with per-slot enable, pending and write-1-to-clear acknowledge registers.

## Interface
Parameters:
- NUM_SLOTS, 8: slots per frame, 2..32.
- LEN_WIDTH, 24: slot-length counter width in cycles.
- ADDR_WIDTH, 8: register byte-address width.

Ports:
- ACLK  in  1  sole clock. All logic is rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- cfg_wr_en  in  1  register write strobe, single cycle.
- cfg_rd_en  in  1  register read strobe, single cycle.
- cfg_addr  in  ADDR_WIDTH  byte address, word aligned.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data, valid when cfg_rvalid is high.
- cfg_rvalid  out  1  read-data strobe, one cycle.
- sync_in  in  1  external frame-sync pulse, synchronous to ACLK, rising-edge detected.
- slot_active  out  NUM_SLOTS  one-hot active slot. All zero when not running.
- slot_index  out  $clog2(NUM_SLOTS)  index of the current slot.
- frame_start  out  1  one-cycle pulse on entry to slot 0.
- irq  out  1  level interrupt.

## Operation
Register map (32-bit words):
- 0x00 CTRL, RW: bit0 RUN, bit1 SYNC_EN, bit2 GIE.
- 0x04 IRQ_EN, RW: [NUM_SLOTS-1:0].
- 0x08 IRQ_PEND, RO.
- 0x0C IRQ_ACK, WO: W1C on PEND. Reads return 0.
- 0x10 STATUS, RO: [4:0] slot_index, [7:6] state, [31:16] frame_count mod 2^16.
- 0x14 RESYNC_CNT, RO: 16-bit saturating count of sync-forced restarts.
- 0x40+4*i SLOT_LEN[i], RW: LEN_WIDTH bits. A value of 0 is treated as 1.
- Unmapped addresses read 0. Writes to unmapped addresses are ignored.

States:
- IDLE: entered at reset or whenever RUN=0. Outputs are quiet. Any state goes to IDLE one cycle after RUN is cleared.
- WAIT_SYNC: entered from IDLE when RUN=1 and SYNC_EN=1. Moves to RUN on a sync_in rising edge.
- RUN: entered from IDLE when RUN=1 and SYNC_EN=0, or from WAIT_SYNC. Always starts at slot 0.

Behaviour in RUN:
- On slot entry, SLOT_LEN[i] is latched into a shadow down-counter. Writes made during a slot take effect the next time that slot is entered.
- At the last cycle of a slot, the sequencer advances to slot i+1. After slot NUM_SLOTS-1 it wraps to slot 0, asserts frame_start and increments frame_count.
- With SYNC_EN=1, a sync_in rising edge restarts at slot 0 on the next cycle and increments RESYNC_CNT. An edge that coincides with a natural wrap to slot 0 is not counted.
- On entry to slot i with IRQ_EN[i]=1, PEND[i] is set.
- If a set and an ACK hit the same bit in the same cycle, the set wins.
- irq = GIE & |PEND, registered.

## Timing
- Reset values: all registers 0, state IDLE, and every output 0.
- Write of RUN=1 sampled at edge t: at t+1 slot_active=1, slot_index=0, frame_start=1.
- A slot with length L holds slot_active for exactly L cycles.
- A sync edge sampled at edge t places slot 0 at t+1.
- PEND sets one cycle after slot entry. irq follows PEND by one further cycle.
- Register reads return cfg_rdata and cfg_rvalid exactly one cycle after cfg_rd_en.
- Register writes are visible to a read issued in the following cycle.
- Simultaneous cfg_wr_en and cfg_rd_en are both serviced; the read returns the pre-write value.
- Reset asserted mid-frame clears everything immediately (asynchronous). Operation resumes only after software writes RUN again.

## Structure
- Package tdma_seq_pkg holds:
  - register offset constants;
  - the state enum (IDLE=0, WAIT_SYNC=1, RUN=2);
  - CTRL bit positions.
- One sub-module, tdma_seq_regs, contains the register file, PEND/ACK logic and read mux.
- The top level holds the FSM, slot counters and outputs.

## Test plan
- Basic frame: NUM_SLOTS=4 with lengths 3,1,0,5, then RUN=1. Required: slot lengths 3,1,1,5 cycles, frame_start every 10 cycles, frame_count increments.
- Interrupt: IRQ_EN=0x4, GIE=1. Required: PEND=0x4 and irq high 2 cycles after slot 2 entry. Writing ACK=0x4 clears PEND and drops irq. ACK in the same cycle as re-entry leaves PEND=0x4.
- Sync lock: SYNC_EN=1, RUN=1. Required: slot_active=0 until the sync edge, slot 0 the next cycle. A mid-slot-2 edge restarts at slot 0 and gives RESYNC_CNT=1.
- Shadow length: rewrite SLOT_LEN[1] from 4 to 8 during slot 1. Required: current slot lasts 4 cycles and the next frame's slot 1 lasts 8.
- Stop and reset: clearing RUN mid-slot zeroes outputs the next cycle. ARESET mid-frame zeroes all outputs and registers asynchronously, and STATUS reads 0.
- Register bus: read of an unmapped address 0x30 returns 0 with cfg_rvalid one cycle later. Read of IRQ_ACK returns 0.

Source files
------------

// File: rtl/tdma_seq_pkg.sv
// Shared definitions for the TDMA slot sequencer: register map offsets,
// FSM state encoding and CTRL bit positions.
package tdma_seq_pkg;

  localparam logic [31:0] OFF_CTRL       = 32'h00;
  localparam logic [31:0] OFF_IRQ_EN     = 32'h04;
  localparam logic [31:0] OFF_IRQ_PEND   = 32'h08;
  localparam logic [31:0] OFF_IRQ_ACK    = 32'h0C;
  localparam logic [31:0] OFF_STATUS     = 32'h10;
  localparam logic [31:0] OFF_RESYNC_CNT = 32'h14;
  localparam logic [31:0] OFF_SLOT_LEN   = 32'h40;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_SYNC_EN = 1;
  localparam int CTRL_GIE     = 2;

endpackage

// File: rtl/tdma_seq_regs.sv
// Register file for the TDMA slot sequencer: CTRL, IRQ enable/pending/ack,
// per-slot lengths and the registered read port.
module tdma_seq_regs
  import tdma_seq_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int LEN_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic                         rd_en_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [31:0]                  wdata_i,
  output logic [31:0]                  rdata_o,
  output logic                         rvalid_o,
  input  logic [$clog2(NUM_SLOTS)-1:0] len_sel_i,
  output logic [LEN_WIDTH-1:0]         len_o,
  input  logic                         entry_i,
  input  logic [$clog2(NUM_SLOTS)-1:0] entry_idx_i,
  input  state_e                       state_i,
  input  logic [$clog2(NUM_SLOTS)-1:0] idx_i,
  input  logic [15:0]                  frame_cnt_i,
  input  logic [15:0]                  resync_cnt_i,
  output logic                         run_o,
  output logic                         sync_en_o,
  output logic                         irq_o
);

  localparam int IW = $clog2(NUM_SLOTS);

  logic [2:0]            ctrl_q;
  logic [NUM_SLOTS-1:0]  irq_en_q, pend_q, pend_d, ack_s, set_s;
  logic [LEN_WIDTH-1:0]  slot_len_q [NUM_SLOTS];
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, irq_q;
  logic [ADDR_WIDTH-1:0] slot_off_s;
  logic [IW-1:0]         slot_sel_s;
  logic                  slot_hit_s;
  logic                  unused_s;

  assign slot_off_s = addr_i - OFF_SLOT_LEN[ADDR_WIDTH-1:0];
  assign slot_sel_s = slot_off_s[IW+1:2];
  assign slot_hit_s = (addr_i >= OFF_SLOT_LEN[ADDR_WIDTH-1:0]) && (slot_off_s[1:0] == 2'b00) &&
                      (32'(slot_off_s) < 32'(4 * NUM_SLOTS));
  assign unused_s   = ^wdata_i;

  // A slot-entry set and a W1C acknowledge on the same bit resolve in favour of the set.
  always_comb begin
    ack_s = {NUM_SLOTS{1'b0}};
    set_s = {NUM_SLOTS{1'b0}};
    if (wr_en_i && (addr_i == OFF_IRQ_ACK[ADDR_WIDTH-1:0])) begin
      ack_s = wdata_i[NUM_SLOTS-1:0];
    end else begin
      ack_s = {NUM_SLOTS{1'b0}};
    end
    if (entry_i && irq_en_q[entry_idx_i]) begin
      set_s = NUM_SLOTS'(1'b1) << entry_idx_i;
    end else begin
      set_s = {NUM_SLOTS{1'b0}};
    end
    pend_d = (pend_q & ~ack_s) | set_s;
  end

  always_comb begin
    rdata_d = 32'h0;
    if (addr_i == OFF_CTRL[ADDR_WIDTH-1:0]) begin
      rdata_d = {29'h0, ctrl_q};
    end else if (addr_i == OFF_IRQ_EN[ADDR_WIDTH-1:0]) begin
      rdata_d = 32'(irq_en_q);
    end else if (addr_i == OFF_IRQ_PEND[ADDR_WIDTH-1:0]) begin
      rdata_d = 32'(pend_q);
    end else if (addr_i == OFF_STATUS[ADDR_WIDTH-1:0]) begin
      rdata_d = {frame_cnt_i, 8'h00, state_i, 1'b0, 5'(idx_i)};
    end else if (addr_i == OFF_RESYNC_CNT[ADDR_WIDTH-1:0]) begin
      rdata_d = {16'h0000, resync_cnt_i};
    end else if (slot_hit_s) begin
      rdata_d = 32'(slot_len_q[slot_sel_s]);
    end else begin
      rdata_d = 32'h0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q   <= 3'b000;
      irq_en_q <= {NUM_SLOTS{1'b0}};
      pend_q   <= {NUM_SLOTS{1'b0}};
      irq_q    <= 1'b0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_len_q[i] <= {LEN_WIDTH{1'b0}};
      end
    end else begin
      if (wr_en_i) begin
        if (addr_i == OFF_CTRL[ADDR_WIDTH-1:0]) begin
          ctrl_q <= wdata_i[2:0];
        end else if (addr_i == OFF_IRQ_EN[ADDR_WIDTH-1:0]) begin
          irq_en_q <= wdata_i[NUM_SLOTS-1:0];
        end else if (slot_hit_s) begin
          slot_len_q[slot_sel_s] <= wdata_i[LEN_WIDTH-1:0];
        end
      end
      pend_q   <= pend_d;
      irq_q    <= ctrl_q[CTRL_GIE] & (|pend_q);
      rvalid_q <= rd_en_i;
      rdata_q  <= rd_en_i ? rdata_d : 32'h0;
    end
  end

  assign len_o     = slot_len_q[len_sel_i];
  assign run_o     = ctrl_q[CTRL_RUN];
  assign sync_en_o = ctrl_q[CTRL_SYNC_EN];
  assign irq_o     = irq_q;
  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;

endmodule

// File: rtl/tdma_slot_sequencer.sv
// Multi-slot TDMA frame generator: slot FSM, per-slot down-counter, sync lock
// and registered slot/frame outputs around the tdma_seq_regs register file.
module tdma_slot_sequencer
  import tdma_seq_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int LEN_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         cfg_wr_en,
  input  logic                         cfg_rd_en,
  input  logic [ADDR_WIDTH-1:0]        cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  output logic [31:0]                  cfg_rdata,
  output logic                         cfg_rvalid,
  input  logic                         sync_in,
  output logic [NUM_SLOTS-1:0]         slot_active,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_index,
  output logic                         frame_start,
  output logic                         irq
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1'b1);

  state_e               state_q;
  logic [IW-1:0]        idx_q, nxt_idx_s;
  logic [LEN_WIDTH-1:0] cnt_q, len_s, len_m1_s;
  logic [NUM_SLOTS-1:0] active_q;
  logic                 frame_start_q, entry_q, sync_q, sync_prev_q;
  logic [15:0]          frame_cnt_q, resync_cnt_q;
  logic                 run_s, sync_en_s, sync_edge_s, last_s, wrap_s, enter_s, resync_s;

  tdma_seq_regs #(
    .NUM_SLOTS (NUM_SLOTS),
    .LEN_WIDTH (LEN_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regs (
    .clk_i       (ACLK),
    .rst_i       (ARESET),
    .wr_en_i     (cfg_wr_en),
    .rd_en_i     (cfg_rd_en),
    .addr_i      (cfg_addr),
    .wdata_i     (cfg_wdata),
    .rdata_o     (cfg_rdata),
    .rvalid_o    (cfg_rvalid),
    .len_sel_i   (nxt_idx_s),
    .len_o       (len_s),
    .entry_i     (entry_q),
    .entry_idx_i (idx_q),
    .state_i     (state_q),
    .idx_i       (idx_q),
    .frame_cnt_i (frame_cnt_q),
    .resync_cnt_i(resync_cnt_q),
    .run_o       (run_s),
    .sync_en_o   (sync_en_s),
    .irq_o       (irq)
  );

  // sync_in is registered before edge detection, so slot 0 follows the sampling edge by one cycle.
  assign sync_edge_s = sync_q & ~sync_prev_q;
  assign last_s      = (cnt_q == LEN_ZERO);
  assign wrap_s      = (state_q == ST_RUN) && last_s && (idx_q == IW'(NUM_SLOTS - 1));
  assign len_m1_s    = (len_s == LEN_ZERO) ? LEN_ZERO : (len_s - LEN_ONE);

  always_comb begin
    enter_s   = 1'b0;
    resync_s  = 1'b0;
    nxt_idx_s = {IW{1'b0}};
    if (run_s) begin
      case (state_q)
        ST_IDLE:      enter_s = ~sync_en_s;
        ST_WAIT_SYNC: enter_s = sync_edge_s;
        ST_RUN: begin
          if (sync_en_s && sync_edge_s) begin
            enter_s  = 1'b1;
            resync_s = ~wrap_s;
          end else if (last_s) begin
            enter_s   = 1'b1;
            nxt_idx_s = wrap_s ? {IW{1'b0}} : (idx_q + IW'(1'b1));
          end else begin
            enter_s = 1'b0;
          end
        end
        default: enter_s = 1'b0;
      endcase
    end else begin
      enter_s = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      idx_q         <= {IW{1'b0}};
      cnt_q         <= LEN_ZERO;
      active_q      <= {NUM_SLOTS{1'b0}};
      frame_start_q <= 1'b0;
      entry_q       <= 1'b0;
      sync_q        <= 1'b0;
      sync_prev_q   <= 1'b0;
      frame_cnt_q   <= 16'h0000;
      resync_cnt_q  <= 16'h0000;
    end else begin
      sync_q        <= sync_in;
      sync_prev_q   <= sync_q;
      entry_q       <= enter_s;
      frame_start_q <= enter_s && (nxt_idx_s == {IW{1'b0}});
      if (enter_s) begin
        state_q  <= ST_RUN;
        idx_q    <= nxt_idx_s;
        cnt_q    <= len_m1_s;
        active_q <= NUM_SLOTS'(1'b1) << nxt_idx_s;
      end else if (!run_s) begin
        state_q  <= ST_IDLE;
        idx_q    <= {IW{1'b0}};
        cnt_q    <= LEN_ZERO;
        active_q <= {NUM_SLOTS{1'b0}};
      end else if (state_q == ST_IDLE) begin
        state_q <= ST_WAIT_SYNC;
      end else if (state_q == ST_RUN) begin
        cnt_q <= cnt_q - LEN_ONE;
      end
      if (run_s && wrap_s) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (resync_s && (resync_cnt_q != 16'hFFFF)) begin
        resync_cnt_q <= resync_cnt_q + 16'd1;
      end
    end
  end

  assign slot_active = active_q;
  assign slot_index  = idx_q;
  assign frame_start = frame_start_q;

endmodule
